// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: instruction type codes and the stage occupancy enum.
package pipe_stage_reg_pkg;

  localparam int OP_ALU = 0;
  localparam int OP_LW  = 1;
  localparam int OP_SW  = 2;
  localparam int OP_BR  = 3;
  localparam int OP_JAL = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) buffer with a registered in_ready; outputs come from main only.
// Handshake: a beat moves when valid & ready are both high at a clock edge; valid never waits on ready.
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  input  logic         out_ready,
  output logic [W-1:0] out_payload,
  output stage_state_e state
);

  stage_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_payload;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          skid_d  = in_payload;
          state_d = ST_TWO;
        end else if (out_xfer && !in_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer && out_xfer) begin
          main_d = in_payload;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_payload = main_q;
  assign state       = state_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with skid buffering and post-hazard squashing of memory (and
// optionally register-write) side effects for KILL_N beats after a load/taken branch/jump.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TYPE_W     = 4,
  parameter int KILL_N     = 1,
  parameter int KILL_REGWR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TYPE_W-1:0] in_type,
  input  logic              in_br_taken,
  input  logic              in_reg_wr_en,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TYPE_W-1:0] out_type,
  output logic              out_reg_wr_en,
  output logic              out_is_load,
  output logic              out_is_store,
  output logic              kill_active
);

  localparam int PW = DATA_W + TYPE_W + 3;
  localparam logic [1:0] KILL_LOAD = 2'(KILL_N);

  logic [1:0]    kill_q, kill_d;
  logic          in_xfer, hazard, squash;
  logic [PW-1:0] buf_in, buf_out;
  stage_state_e  buf_state;

  assign in_xfer = in_valid & in_ready;
  assign hazard  = (in_type == TYPE_W'(OP_LW)) ||
                   ((in_type == TYPE_W'(OP_BR)) && in_br_taken) ||
                   (in_type == TYPE_W'(OP_JAL));
  assign squash  = (kill_q != 2'd0);

  // A squashed beat keeps its data and type; only side-effect flags are cleared.
  assign buf_in = {in_data, in_type,
                   in_reg_wr_en & ~(squash & (KILL_REGWR != 0)),
                   in_is_load & ~squash,
                   in_is_store & ~squash};

  always_comb begin
    kill_d = kill_q;
    if (flush) begin
      kill_d = 2'd0;
    end else if (in_xfer) begin
      if (hazard) kill_d = KILL_LOAD;
      else if (squash) kill_d = kill_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) kill_q <= 2'd0;
    else       kill_q <= kill_d;
  end

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (buf_in),
    .out_ready  (out_ready),
    .out_payload(buf_out),
    .state      (buf_state)
  );

  assign out_valid   = (buf_state != ST_EMPTY);
  assign kill_active = squash;
  assign {out_data, out_type, out_reg_wr_en, out_is_load, out_is_store} = buf_out;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven in lockstep against a queue-based model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_type = '0;
  logic        in_br_taken = 1'b0, in_reg_wr_en = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic [2:0]  o_valid, o_ready, o_rw, o_ld, o_st, o_kill;
  logic [31:0] o_data [3];
  logic [3:0]  o_type [3];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  typ;
    logic [2:0]  rw;
    logic [2:0]  ld;
    logic [2:0]  st;
  } beat_t;

  beat_t mq[$];
  int    kill_m [3];
  int    kn [3] = '{1, 2, 0};
  int    kr [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  pipe_stage_reg #(.KILL_N(1), .KILL_REGWR(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[0]), .in_data(in_data),
    .in_type(in_type), .in_br_taken(in_br_taken), .in_reg_wr_en(in_reg_wr_en),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .flush(flush), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_data(o_data[0]), .out_type(o_type[0]), .out_reg_wr_en(o_rw[0]),
    .out_is_load(o_ld[0]), .out_is_store(o_st[0]), .kill_active(o_kill[0]));

  pipe_stage_reg #(.KILL_N(2), .KILL_REGWR(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[1]), .in_data(in_data),
    .in_type(in_type), .in_br_taken(in_br_taken), .in_reg_wr_en(in_reg_wr_en),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .flush(flush), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_data(o_data[1]), .out_type(o_type[1]), .out_reg_wr_en(o_rw[1]),
    .out_is_load(o_ld[1]), .out_is_store(o_st[1]), .kill_active(o_kill[1]));

  pipe_stage_reg #(.KILL_N(0), .KILL_REGWR(0)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[2]), .in_data(in_data),
    .in_type(in_type), .in_br_taken(in_br_taken), .in_reg_wr_en(in_reg_wr_en),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .flush(flush), .out_valid(o_valid[2]),
    .out_ready(out_ready), .out_data(o_data[2]), .out_type(o_type[2]), .out_reg_wr_en(o_rw[2]),
    .out_is_load(o_ld[2]), .out_is_store(o_st[2]), .kill_active(o_kill[2]));

  // Reference model: FIFO of at most two beats; the stage is ready whenever it holds fewer than two.
  function automatic void model_step();
    bit    ixf, oxf, hz, sq;
    beat_t b;
    if (reset || flush) begin
      mq.delete();
      for (int k = 0; k < 3; k++) kill_m[k] = 0;
      return;
    end
    ixf = in_valid && (mq.size() < 2);
    oxf = (mq.size() > 0) && out_ready;
    if (oxf) void'(mq.pop_front());
    if (ixf) begin
      hz = (in_type == 4'd1) || (in_type == 4'd3 && in_br_taken) || (in_type == 4'd4);
      b.data = in_data;
      b.typ  = in_type;
      for (int k = 0; k < 3; k++) begin
        sq = kill_m[k] > 0;
        b.ld[k] = in_is_load && !sq;
        b.st[k] = in_is_store && !sq;
        b.rw[k] = in_reg_wr_en && !(sq && kr[k] != 0);
        if (hz) kill_m[k] = kn[k];
        else if (sq) kill_m[k] = kill_m[k] - 1;
      end
      mq.push_back(b);
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input logic [3:0] t, input bit br,
                       input bit rw, input bit ld, input bit st);
    in_valid = v; in_data = d; in_type = t; in_br_taken = br;
    in_reg_wr_en = rw; in_is_load = ld; in_is_store = st;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    checks++;
    if (o_valid !== 3'b000 || o_ready !== 3'b111 || o_kill !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl valid=%b ready=%b kill=%b exp 000/111/000", o_valid, o_ready, o_kill);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_data[k] !== 32'h0 || o_type[k] !== 4'h0 || o_rw[k] !== 1'b0 || o_ld[k] !== 1'b0 || o_st[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_data dut%0d data=%h type=%h flags=%b%b%b exp all 0", k, o_data[k], o_type[k], o_rw[k], o_ld[k], o_st[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1, 32'h1234, 4'd0, 0, 1, 0, 0);
    cycle();
    checks++;
    if (o_valid !== 3'b111 || o_data[0] !== 32'h1234 || o_ready !== 3'b111) begin
      errors++;
      $display("FAIL single_beat valid=%b data=%h ready=%b exp 111/1234/111", o_valid, o_data[0], o_ready);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    checks++;
    if (o_valid !== 3'b000) begin
      errors++;
      $display("FAIL single_drain valid=%b exp 000", o_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1, 32'hA, 4'd0, 0, 1, 0, 0); cycle();
    checks++;
    if (o_ready !== 3'b111 || o_data[0] !== 32'hA) begin
      errors++; $display("FAIL bp_first ready=%b data=%h exp 111/a", o_ready, o_data[0]);
    end
    drive(1, 32'hB, 4'd0, 0, 1, 0, 0); cycle();
    checks++;
    if (o_ready !== 3'b000 || o_valid !== 3'b111) begin
      errors++; $display("FAIL bp_full ready=%b valid=%b exp 000/111", o_ready, o_valid);
    end
    drive(1, 32'hC, 4'd0, 0, 1, 0, 0); cycle();
    checks++;
    if (o_ready !== 3'b000 || o_data[1] !== 32'hA) begin
      errors++; $display("FAIL bp_hold ready=%b data=%h exp 000/a", o_ready, o_data[1]);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    cycle();
    checks++;
    if (o_valid !== 3'b111 || o_data[2] !== 32'hB || o_ready !== 3'b111) begin
      errors++; $display("FAIL bp_drain valid=%b data=%h ready=%b exp 111/b/111", o_valid, o_data[2], o_ready);
    end
    cycle();
    checks++;
    if (o_valid !== 3'b000) begin
      errors++; $display("FAIL bp_empty valid=%b exp 000 (beat C must not appear)", o_valid);
    end
  endtask

  task automatic test_kill1();
    out_ready = 1'b1;
    drive(1, 32'h100, 4'd1, 0, 1, 1, 0); cycle();
    checks++;
    if (o_ld !== 3'b111 || o_kill !== 3'b011) begin
      errors++; $display("FAIL kill1_lw ld=%b kill=%b exp 111/011", o_ld, o_kill);
    end
    drive(1, 32'h104, 4'd2, 0, 0, 0, 1); cycle();
    checks++;
    if (o_st !== 3'b100 || o_type[0] !== 4'd2 || o_data[0] !== 32'h104 || o_kill !== 3'b010) begin
      errors++; $display("FAIL kill1_sw1 st=%b type=%h data=%h kill=%b exp 100/2/104/010", o_st, o_type[0], o_data[0], o_kill);
    end
    drive(1, 32'h108, 4'd2, 0, 0, 0, 1); cycle();
    checks++;
    if (o_st !== 3'b101 || o_kill !== 3'b000) begin
      errors++; $display("FAIL kill1_sw2 st=%b kill=%b exp 101/000", o_st, o_kill);
    end
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
  endtask

  task automatic test_kill2();
    out_ready = 1'b1;
    drive(1, 32'h200, 4'd4, 0, 1, 0, 0); cycle();
    checks++;
    if (o_rw !== 3'b111 || o_kill !== 3'b011) begin
      errors++; $display("FAIL kill2_jal rw=%b kill=%b exp 111/011", o_rw, o_kill);
    end
    drive(1, 32'h204, 4'd0, 0, 1, 0, 0); cycle();
    checks++;
    if (o_rw !== 3'b101) begin
      errors++; $display("FAIL kill2_add1 rw=%b exp 101", o_rw);
    end
    drive(1, 32'h208, 4'd0, 0, 1, 0, 0); cycle();
    checks++;
    if (o_rw !== 3'b101 || o_kill !== 3'b000) begin
      errors++; $display("FAIL kill2_add2 rw=%b kill=%b exp 101/000", o_rw, o_kill);
    end
    drive(1, 32'h20C, 4'd3, 0, 0, 0, 0); cycle();
    checks++;
    if (o_kill !== 3'b000) begin
      errors++; $display("FAIL kill2_br_nt kill=%b exp 000", o_kill);
    end
    drive(1, 32'h210, 4'd0, 0, 1, 1, 0); cycle();
    checks++;
    if (o_rw !== 3'b111 || o_ld !== 3'b111) begin
      errors++; $display("FAIL kill2_after_br rw=%b ld=%b exp 111/111", o_rw, o_ld);
    end
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1, 32'h300, 4'd0, 0, 1, 0, 0); cycle();
    drive(1, 32'h304, 4'd4, 0, 1, 0, 0); cycle();
    checks++;
    if (o_ready !== 3'b000 || o_kill !== 3'b011) begin
      errors++; $display("FAIL flush_setup ready=%b kill=%b exp 000/011", o_ready, o_kill);
    end
    flush = 1'b1;
    drive(1, 32'hDEAD, 4'd0, 0, 1, 0, 0); cycle();
    checks++;
    if (o_valid !== 3'b000 || o_ready !== 3'b111 || o_kill !== 3'b000) begin
      errors++; $display("FAIL flush_now valid=%b ready=%b kill=%b exp 000/111/000", o_valid, o_ready, o_kill);
    end
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    cycle(); cycle();
    checks++;
    if (o_valid !== 3'b000) begin
      errors++; $display("FAIL flush_ghost valid=%b exp 000", o_valid);
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    drive(1, 32'h55, 4'd1, 0, 1, 1, 0); cycle();
    drive(1, 32'h66, 4'd2, 0, 0, 0, 1); cycle();
    reset = 1'b1;
    flush = 1'b1;
    drive(1, 32'h77, 4'd0, 0, 1, 0, 0); cycle();
    checks++;
    if (o_valid !== 3'b000 || o_ready !== 3'b111 || o_kill !== 3'b000 ||
        o_data[0] !== 32'h0 || o_data[1] !== 32'h0 || o_type[1] !== 4'h0 ||
        o_rw !== 3'b000 || o_ld !== 3'b000 || o_st !== 3'b000) begin
      errors++;
      $display("FAIL reset_flush valid=%b ready=%b kill=%b data0=%h data1=%h rw=%b ld=%b st=%b exp reset values",
               o_valid, o_ready, o_kill, o_data[0], o_data[1], o_rw, o_ld, o_st);
    end
    reset = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [3:0] types [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, types[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_valid[k] !== (mq.size() > 0) || o_ready[k] !== (mq.size() < 2) || o_kill[k] !== (kill_m[k] > 0)) begin
          errors++;
          $display("FAIL rand_ctrl n=%0d dut%0d valid=%b ready=%b kill=%b exp %0d/%0d/%0d", n, k,
                   o_valid[k], o_ready[k], o_kill[k], mq.size() > 0, mq.size() < 2, kill_m[k] > 0);
        end
        if (mq.size() > 0) begin
          checks++;
          if (o_data[k] !== mq[0].data || o_type[k] !== mq[0].typ || o_rw[k] !== mq[0].rw[k] ||
              o_ld[k] !== mq[0].ld[k] || o_st[k] !== mq[0].st[k]) begin
            errors++;
            $display("FAIL rand_beat n=%0d dut%0d got %h/%h/%b%b%b exp %h/%h/%b%b%b", n, k,
                     o_data[k], o_type[k], o_rw[k], o_ld[k], o_st[k],
                     mq[0].data, mq[0].typ, mq[0].rw[k], mq[0].ld[k], mq[0].st[k]);
          end
        end
      end
    end
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_kill1();
    test_kill2();
    test_flush();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
